// File: rtl/acc_sat_int16_int18_if.sv
// Handshake bundle for the INT16 -> INT18 saturating group accumulator.
//   len_i              : group length, sampled on the first beat of a group
//   in_valid/in_ready  : input sample handshake, in_data is the signed sample
//   out_valid/out_ready: result handshake, out_data is the signed group sum
//   out_ovf            : saturation happened somewhere in the group
// master = sample producer / result consumer, slave = accumulator.
interface acc_sat_int16_int18_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 18,
   parameter int LEN_W = 8
);
   logic        [LEN_W-1:0] len_i;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_ovf;

   modport master (
      output len_i, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  len_i, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/acc_sat_int16_int18.sv
// Streaming signed accumulator: sums a programmable-length group of INT16
// samples into a saturated INT18 result, the widening end of the
// INT16 -> INT18 -> INT16 datapath.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of acc_sat_int16_int18_if (sample in, result out)
//   busy  : a group is in progress or a result is waiting (state != IDLE)
//
// state | meaning
// IDLE  | waiting for the first sample of a group
// ACC   | accumulating remaining samples of the group
// HOLD  | result presented, waiting for the output beat
module acc_sat_int16_int18 #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 18,
   parameter int LEN_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   acc_sat_int16_int18_if.slave bus,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

   state_t                  state;
   logic signed [OUT_W-1:0] acc;
   logic        [LEN_W-1:0] cnt;
   logic        [LEN_W-1:0] len_q;
   logic                    ovf;

   logic signed [OUT_W:0]   sum_w;
   logic signed [OUT_W-1:0] sat_val;
   logic signed [OUT_W-1:0] in_sext;
   logic                    sat_hit;
   logic        [LEN_W-1:0] len_eff;
   logic        [LEN_W:0]   cnt_inc;
   logic                    in_beat;
   logic                    out_beat;

   always_comb begin
      in_sext = {{(OUT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
      // One guard bit: the top two bits disagree exactly when the sum left
      // the OUT_W range, and the guard bit gives the direction.
      sum_w   = {acc[OUT_W-1], acc} + {in_sext[OUT_W-1], in_sext};
      sat_hit = sum_w[OUT_W] != sum_w[OUT_W-1];
      sat_val = sum_w[OUT_W-1:0];
      if (sat_hit) begin
         sat_val = sum_w[OUT_W] ? MIN_V : MAX_V;
      end
      len_eff  = (bus.len_i == '0) ? LEN_W'(1) : bus.len_i;
      cnt_inc  = {1'b0, cnt} + (LEN_W+1)'(1);
      in_beat  = bus.in_valid & bus.in_ready;
      out_beat = bus.out_valid & bus.out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         len_q         <= '0;
         ovf           <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ovf   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_beat) begin
                  len_q <= len_eff;
                  acc   <= in_sext;
                  cnt   <= LEN_W'(1);
                  ovf   <= 1'b0;
                  busy  <= 1'b1;
                  if (len_eff == LEN_W'(1)) begin
                     state         <= HOLD;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= in_sext;
                     bus.out_ovf   <= 1'b0;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            ACC: begin
               if (in_beat) begin
                  acc <= sat_val;
                  ovf <= ovf | sat_hit;
                  cnt <= cnt_inc[LEN_W-1:0];
                  if (cnt_inc == {1'b0, len_q}) begin
                     state         <= HOLD;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= sat_val;
                     bus.out_ovf   <= ovf | sat_hit;
                  end
               end
            end
            HOLD: begin
               if (out_beat) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule
